// File: rtl/variable_decl_pkg.sv
// variable_decl_pkg
// Shared types, constants and the lane fold helper for variable_decl_accum.
//   vd_state_e      : run state (IDLE, ACCUM, DONE)
//   VD_DEFAULT_SEED : default lane seed / fold constant
//   vd_fold()       : XOR of all packed lanes, XORed with the seed
package variable_decl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } vd_state_e;

  localparam logic [7:0] VD_DEFAULT_SEED = 8'hAA;

  // Upper bounds for the fold helper: lanes are packed into a fixed-size
  // vector so the function stays independent of the instance parameters.
  localparam int unsigned VD_MAX_W     = 64;
  localparam int unsigned VD_MAX_LANES = 32;
  localparam int unsigned VD_MAX_BITS  = 256;

  // Folds nlanes lanes of the given width (lane l at [l*width +: width]).
  // Temporaries are automatic, so every call starts from a clean state.
  function automatic logic [VD_MAX_W-1:0] vd_fold(
    input logic [VD_MAX_BITS-1:0] lanes,
    input logic [VD_MAX_W-1:0]    seed,
    input int unsigned            width,
    input int unsigned            nlanes
  );
    logic [VD_MAX_W-1:0] acc;
    logic [VD_MAX_W-1:0] mask;
    acc  = seed;
    mask = (width >= VD_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    for (int unsigned i = 0; i < VD_MAX_LANES; i++) begin
      if (i < nlanes) begin
        acc = acc ^ VD_MAX_W'(lanes >> (i * width));
      end
    end
    return acc & mask;
  endfunction

endpackage

// File: rtl/variable_decl_lane.sv
// variable_decl_lane
// One accumulator lane: loads a seed, then adds (data + 1) on every enabled
// cycle, wrapping modulo 2^WIDTH.
//   clk, rst : clock, asynchronous active-high reset (lane clears to 0)
//   i_load   : load i_seed into the lane
//   i_en     : accept i_data this cycle
//   i_seed   : seed value
//   i_data   : lane data
//   o_next   : value the lane takes if i_en is high (combinational)
module variable_decl_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_seed,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_acc;

  assign o_next = r_acc + i_data + WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_seed;
    end else if (i_en) begin
      r_acc <= o_next;
    end
  end

endmodule

// File: rtl/variable_decl_accum.sv
// variable_decl_accum
// Multi-lane accumulator. A run seeds every lane, accepts COUNT beats
// (each lane adds data + 1), then folds all lanes with the seed into a
// registered result held until acknowledged.
// Optional feature macro: VARDECL_PARITY_EN adds result_parity_out.
//   clk, rst          : clock, asynchronous active-high reset
//   start_in          : begin a run (IDLE only)
//   data_in           : LANES*WIDTH bits, lane l at [l*WIDTH +: WIDTH]
//   valid_in          : beat present
//   ready_out         : high while in ACCUM
//   result_out        : folded result (registered)
//   result_valid_out  : result valid, held until result_ack_in
//   result_ack_in     : consumer acknowledge
//   result_parity_out : ^result_out (VARDECL_PARITY_EN only)
module variable_decl_accum
  import variable_decl_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter int          LANES = 2,
  parameter int          COUNT = 4,
  parameter logic [63:0] SEED  = 64'(VD_DEFAULT_SEED)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_in,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [WIDTH-1:0]       result_out,
  output logic                   result_valid_out,
  input  logic                   result_ack_in
`ifdef VARDECL_PARITY_EN
  ,
  output logic                   result_parity_out
`endif
);

  localparam int CW = $clog2(COUNT + 1);

  vd_state_e r_state;
  vd_state_e w_state_next;

  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_result;
  logic                   r_result_valid;

  logic                   w_load;
  logic                   w_accept;
  logic                   w_last;
  logic [WIDTH-1:0]       w_seed;
  logic [LANES*WIDTH-1:0] w_next_flat;
  logic [VD_MAX_BITS-1:0] w_lanes_ext;
  logic [WIDTH-1:0]       w_fold;

  assign w_seed   = SEED[WIDTH-1:0];
  assign w_load   = (r_state == IDLE) && start_in;
  assign w_accept = (r_state == ACCUM) && valid_in;
  assign w_last   = w_accept && (r_cnt == CW'(COUNT - 1));

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    variable_decl_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_en   (w_accept),
      .i_seed (w_seed),
      .i_data (data_in[gi*WIDTH +: WIDTH]),
      .o_next (w_next_flat[gi*WIDTH +: WIDTH])
    );
  end

  // Fold the lanes' next values so the result is captured on the same edge
  // that accepts the final beat.
  always_comb begin
    w_lanes_ext = '0;
    w_lanes_ext[LANES*WIDTH-1:0] = w_next_flat;
  end

  assign w_fold = WIDTH'(vd_fold(w_lanes_ext, SEED, WIDTH, LANES));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start_in) w_state_next = ACCUM;
      ACCUM:   if (w_last) w_state_next = DONE;
      DONE:    if (result_ack_in) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result registers; result_out survives the ack, only valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else if (w_last) begin
      r_result       <= w_fold;
      r_result_valid <= 1'b1;
    end else if ((r_state == DONE) && result_ack_in) begin
      r_result_valid <= 1'b0;
    end
  end

`ifdef VARDECL_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_last) begin
      r_parity <= ^w_fold;
    end
  end

  assign result_parity_out = r_parity;
`endif

  assign ready_out        = (r_state == ACCUM);
  assign result_out       = r_result;
  assign result_valid_out = r_result_valid;

endmodule

// File: tb/tb_variable_decl_accum.sv
module tb_variable_decl_accum;

  localparam int         W     = 8;
  localparam int         L     = 2;
  localparam int         N     = 4;
  localparam logic [7:0] SEEDV = 8'hAA;

  logic           clk;
  logic           rst;
  logic           start_in;
  logic [L*W-1:0] data_in;
  logic           valid_in;
  logic           ready_out;
  logic [W-1:0]   result_out;
  logic           result_valid_out;
  logic           result_ack_in;
`ifdef VARDECL_PARITY_EN
  logic           result_parity_out;
`endif

  int total;
  int bad;

  // Reference model state: running sum of (data + 1) per lane for the run.
  int unsigned sum0;
  int unsigned sum1;
  logic [7:0]  last_exp;

  variable_decl_accum #(
    .WIDTH(W),
    .LANES(L),
    .COUNT(N),
    .SEED (64'(SEEDV))
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_in         (start_in),
    .data_in          (data_in),
    .valid_in         (valid_in),
    .ready_out        (ready_out),
    .result_out       (result_out),
    .result_valid_out (result_valid_out),
    .result_ack_in    (result_ack_in)
`ifdef VARDECL_PARITY_EN
    ,
    .result_parity_out(result_parity_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: value=%0h", tag, got);
    end
  endtask

  function automatic logic [7:0] model_result();
    logic [7:0] l0;
    logic [7:0] l1;
    l0 = 8'((int'(SEEDV) + sum0) % 256);
    l1 = 8'((int'(SEEDV) + sum1) % 256);
    return l0 ^ l1 ^ SEEDV;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_run();
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    sum0 = 0;
    sum1 = 0;
    chk("ready_after_start", ready_out, 1);
  endtask

  task automatic beat(input logic [7:0] d0, input logic [7:0] d1, input int gap);
    valid_in = 1'b1;
    data_in  = {d1, d0};
    step();
    valid_in = 1'b0;
    sum0 += int'(d0) + 1;
    sum1 += int'(d1) + 1;
    repeat (gap) step();
  endtask

  task automatic check_result(input string tag);
    last_exp = model_result();
    chk({tag, "_valid"}, result_valid_out, 1);
    chk({tag, "_ready_low"}, ready_out, 0);
    chk({tag, "_result"}, result_out, last_exp);
`ifdef VARDECL_PARITY_EN
    chk({tag, "_parity"}, result_parity_out, ^last_exp);
`endif
  endtask

  task automatic ack();
    result_ack_in = 1'b1;
    step();
    result_ack_in = 1'b0;
    chk("ack_valid_cleared", result_valid_out, 0);
    chk("ack_result_kept", result_out, last_exp);
    chk("ack_ready_low", ready_out, 0);
  endtask

  // Run COUNT beats of constant data with a fixed gap, but the final beat
  // is never followed by a gap so the result is checked one cycle later.
  task automatic run_const(input string tag, input logic [7:0] d0, input logic [7:0] d1, input int gap);
    start_run();
    for (int i = 0; i < N; i++) beat(d0, d1, (i == N - 1) ? 0 : gap);
    check_result(tag);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b0;
    start_in      = 1'b0;
    valid_in      = 1'b0;
    data_in       = '0;
    result_ack_in = 1'b0;
    sum0          = 0;
    sum1          = 0;
    last_exp      = '0;

    #3 rst = 1'b1;
    step();
    chk("reset_ready", ready_out, 0);
    chk("reset_result", result_out, 0);
    chk("reset_valid", result_valid_out, 0);
`ifdef VARDECL_PARITY_EN
    chk("reset_parity", result_parity_out, 0);
`endif
    rst = 1'b0;
    step();

    // Zero data, distinct lanes, wrap-around
    run_const("zero", 8'h00, 8'h00, 0);
    chk("zero_literal", result_out, 8'hAA);
    ack();
    run_const("distinct", 8'h01, 8'h00, 0);
    chk("distinct_literal", result_out, 8'hB6);
    ack();
    run_const("wrap", 8'hFF, 8'h00, 0);
    chk("wrap_literal", result_out, 8'hAE);
    ack();

    // Gapped input, with valid held high in IDLE and DONE
    valid_in = 1'b1;
    data_in  = 16'h0001;
    repeat (3) step();
    chk("idle_valid_ready_low", ready_out, 0);
    chk("idle_valid_no_result", result_valid_out, 0);
    valid_in = 1'b0;
    start_run();
    for (int i = 0; i < N; i++) beat(8'h01, 8'h00, (i == N - 1) ? 0 : 3);
    check_result("gapped");
    chk("gapped_literal", result_out, 8'hB6);
    valid_in = 1'b1;
    data_in  = 16'h5555;
    repeat (3) step();
    valid_in = 1'b0;
    chk("done_valid_ignored", result_out, 8'hB6);
    chk("done_valid_still", result_valid_out, 1);
    ack();

    // Handshake: hold, then ack together with start
    run_const("hs", 8'h10, 8'h23, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hs_hold_valid", result_valid_out, 1);
      chk("hs_hold_result", result_out, last_exp);
    end
    result_ack_in = 1'b1;
    start_in      = 1'b1;
    step();
    result_ack_in = 1'b0;
    start_in      = 1'b0;
    chk("hs_ack_start_valid", result_valid_out, 0);
    chk("hs_ack_start_ready", ready_out, 0);
    step();
    chk("hs_no_run_ready", ready_out, 0);
    run_const("hs_rerun", 8'h01, 8'h00, 0);
    ack();

    // Reset mid-run
    start_run();
    beat(8'h07, 8'h09, 0);
    beat(8'h07, 8'h09, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", ready_out, 0);
    chk("midrst_result", result_out, 0);
    chk("midrst_valid", result_valid_out, 0);
`ifdef VARDECL_PARITY_EN
    chk("midrst_parity", result_parity_out, 0);
`endif
    step();
    rst = 1'b0;
    step();
    run_const("post_rst", 8'h00, 8'h00, 0);
    chk("post_rst_literal", result_out, 8'hAA);
    ack();

    // Randomized runs
    for (int r = 0; r < 20; r++) begin
      start_run();
      for (int i = 0; i < N; i++) begin
        beat(8'($urandom), 8'($urandom), (i == N - 1) ? 0 : int'($urandom_range(0, 2)));
      end
      check_result("rand");
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        valid_in = 1'($urandom);
        data_in  = 16'($urandom);
        step();
        valid_in = 1'b0;
        chk("rand_hold", result_out, last_exp);
      end
      ack();
      repeat ($urandom_range(0, 2)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
